// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;
  localparam int DEF_XLEN   = 32;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into words; emits a registered 1-cycle word_valid
// with the completed word, leaving the partial register free for the next byte.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);
  logic [1:0]  phase;
  logic [23:0] partial;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        phase <= '0;
      end else if (byte_valid) begin
        case (phase)
          2'd0:    partial[7:0]   <= byte_data;
          2'd1:    partial[15:8]  <= byte_data;
          2'd2:    partial[23:16] <= byte_data;
          default: begin
            word       <= XLEN'({byte_data, partial});
            word_valid <= 1'b1;
          end
        endcase
        phase <= phase + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: length, words, XOR checksum.
// Holds the processor in reset until an image has been written and verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int XLEN   = DEF_XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t      state;
  logic [15:0] len;
  logic [17:0] byte_cnt;
  logic [7:0]  csum;
  logic        xfer, start_ok, last_byte;
  logic [15:0] len_next;

  assign in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CHECK);
  assign xfer      = in_valid & in_ready;
  assign start_ok  = start & ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_next  = {in_data, len[7:0]};
  assign last_byte = (byte_cnt == ({len, 2'b00} - 18'd1));

  word_assembler #(.XLEN(XLEN)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (xfer && (state == S_DATA)),
    .byte_data  (in_data),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      byte_cnt  <= '0;
      csum      <= '0;
      imem_addr <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // Address advances after each strobe; a full 2**ADDR_W image wraps to 0.
      if (imem_we) imem_addr <= imem_addr + 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (state == S_DONE) cpu_reset <= 1'b0;
          if (start) begin
            state     <= S_LEN_LO;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            csum      <= '0;
            byte_cnt  <= '0;
            imem_addr <= '0;
          end
        end
        S_LEN_LO: if (xfer) begin
          len[7:0] <= in_data;
          state    <= S_LEN_HI;
        end
        S_LEN_HI: if (xfer) begin
          len[15:8] <= in_data;
          if (len_next == 16'd0) begin
            state <= S_CHECK;
          end else if ({1'b0, len_next} > MAX_WORDS) begin
            state <= S_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (xfer) begin
          csum     <= csum ^ in_data;
          byte_cnt <= byte_cnt + 18'd1;
          if (last_byte) state <= S_CHECK;
        end
        S_CHECK: if (xfer) begin
          busy <= 1'b0;
          if (in_data == csum) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ERR;
            error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load streams plus hand sequences.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, imem_we, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int ready_bad = 0;
  logic [31:0] mem [256];
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (in_ready && !busy) ready_bad++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap = 0);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    string             name;
    int                n;
    logic [0:15][7:0]  b;
    bit                ed, ee;
    int                nw;
    logic [31:0]       w0, w1;
  } vec_t;

  vec_t v [6];
  logic [31:0] img [256];

  task automatic load_image(input int words, input int maxgap);
    logic [7:0] cs = 8'h00;
    pulse_start();
    send(8'(words), $urandom_range(0, maxgap));
    send(8'(words >> 8), $urandom_range(0, maxgap));
    for (int w = 0; w < words; w++)
      for (int k = 0; k < 4; k++) begin
        cs ^= img[w][8*k +: 8];
        send(img[w][8*k +: 8], $urandom_range(0, maxgap));
      end
    send(cs, $urandom_range(0, maxgap));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    //                 name        n   bytes                                                              done err nw w0            w1
    v[0] = '{"good2",   11, {8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'hB7,8'h00,8'h01,8'h00,8'hA5,40'h0}, 1, 0, 2, 32'h00000013, 32'h000100B7};
    v[1] = '{"badcsum", 11, {8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'hB7,8'h00,8'h01,8'h00,8'h00,40'h0}, 0, 1, 2, 32'h00000013, 32'h000100B7};
    v[2] = '{"len0",     3, {8'h00,8'h00,8'h00,104'h0},                                               1, 0, 0, 32'h0,        32'h0};
    v[3] = '{"len0bad",  3, {8'h00,8'h00,8'h5A,104'h0},                                               0, 1, 0, 32'h0,        32'h0};
    v[4] = '{"one",      7, {8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h22,72'h0},                         1, 0, 1, 32'hDEADBEEF, 32'h0};
    v[5] = '{"len257",   2, {8'h01,8'h01,112'h0},                                                     0, 1, 0, 32'h0,        32'h0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_error",     32'(error),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_addr",      32'(imem_addr), 32'd0);
    chk("rst_wdata",     imem_wdata,     32'd0);
    chk("rst_writes",    32'(wr_data.size()), 32'd0);

    for (int i = 0; i < 6; i++) begin
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      chk({v[i].name, "_start_busy"},  32'(busy),      32'd1);
      chk({v[i].name, "_start_cpurst"}, 32'(cpu_reset), 32'd1);
      chk({v[i].name, "_start_done"},  32'(done),      32'd0);
      for (int k = 0; k < v[i].n; k++) send(v[i].b[k]);
      repeat (3) @(posedge clk);
      #1;
      chk({v[i].name, "_done"},      32'(done),      32'(v[i].ed));
      chk({v[i].name, "_error"},     32'(error),     32'(v[i].ee));
      chk({v[i].name, "_busy"},      32'(busy),      32'd0);
      chk({v[i].name, "_cpu_reset"}, 32'(cpu_reset), 32'(!v[i].ed));
      chk({v[i].name, "_in_ready"},  32'(in_ready),  32'd0);
      chk({v[i].name, "_nwrites"},   32'(wr_data.size()), 32'(v[i].nw));
      for (int j = 0; j < v[i].nw && j < wr_data.size(); j++) begin
        chk({v[i].name, "_waddr"}, 32'(wr_addr[j]), 32'(j));
        chk({v[i].name, "_wdata"}, wr_data[j], (j == 0) ? v[i].w0 : v[i].w1);
      end
    end

    // cpu_reset release timing: still high on DONE entry, low one cycle later
    pulse_start();
    for (int k = 0; k < v[0].n; k++) send(v[0].b[k]);
    chk("timing_done_at_entry",   32'(done),      32'd1);
    chk("timing_cpurst_at_entry", 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
    chk("timing_cpurst_after",    32'(cpu_reset), 32'd0);

    // overflow flagged right after the second length byte
    pulse_start();
    send(8'h01); send(8'h01);
    chk("ovf_error_after_lenhi", 32'(error),    32'd1);
    chk("ovf_in_ready",          32'(in_ready), 32'd0);

    // 64-word image: gap-free and gapped runs must leave identical memory
    for (int w = 0; w < 64; w++) img[w] = $urandom;
    for (int run = 0; run < 2; run++) begin
      int bad = 0;
      for (int w = 0; w < 256; w++) mem[w] = 'x;
      load_image(64, run * 5);
      for (int w = 0; w < 64; w++) if (mem[w] !== img[w]) bad++;
      chk(run ? "img64_gapped_mem" : "img64_nogap_mem", 32'(bad), 32'd0);
      chk(run ? "img64_gapped_done" : "img64_nogap_done", 32'(done), 32'd1);
    end

    // full-size image: last word at addr all-ones, address wraps to 0
    for (int w = 0; w < 256; w++) img[w] = 32'h1000_0000 + 32'(w * 7);
    for (int w = 0; w < 256; w++) mem[w] = 'x;
    load_image(256, 0);
    chk("img256_done",     32'(done),      32'd1);
    chk("img256_last",     mem[255],       32'h1000_0000 + 32'(255 * 7));
    chk("img256_first",    mem[0],         32'h1000_0000);
    chk("img256_addrwrap", 32'(imem_addr), 32'd0);

    // reset mid-load, then a clean reload with an ignored start in the middle
    pulse_start();
    for (int k = 0; k < 6; k++) send(v[0].b[k]);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("midrst_busy",     32'(busy),      32'd0);
    chk("midrst_cpurst",   32'(cpu_reset), 32'd1);
    chk("midrst_in_ready", 32'(in_ready),  32'd0);
    chk("midrst_addr",     32'(imem_addr), 32'd0);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    for (int k = 0; k < v[0].n; k++) begin
      if (k == 3) pulse_start();
      send(v[0].b[k]);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reload_done",    32'(done),           32'd1);
    chk("reload_nwrites", 32'(wr_data.size()), 32'd2);
    if (wr_data.size() == 2) begin
      chk("reload_w0", wr_data[0], 32'h00000013);
      chk("reload_a1", 32'(wr_addr[1]), 32'd1);
      chk("reload_w1", wr_data[1], 32'h000100B7);
    end

    chk("in_ready_outside_load", 32'(ready_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
